nt_subckt_activity_monitor: RTL

//   Downstream observation stage for a single-bit Nt-node subcircuit output (e.g. a registered net).

---
 rtl/nt_subckt_activity_monitor_pkg.sv | 16 +
 rtl/nt_subckt_activity_monitor_if.sv | 31 +++
 rtl/nt_subckt_activity_monitor_toggle_detect.sv | 26 ++
 rtl/nt_subckt_activity_monitor.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/nt_subckt_activity_monitor_pkg.sv
// Shared definitions for the Nt-node subcircuit activity monitor: state
// encodings and default parameter values.
package nt_subckt_activity_monitor_pkg;

  localparam int WIN_LOG2_DEF  = 3;
  localparam int PAT_W_DEF     = 4;
  localparam int TOGGLE_TH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/nt_subckt_activity_monitor_if.sv
// Signal bundle between the observed subcircuit/controller (master) and the
// activity monitor (slave), including the monitor's FSM state for observation.
interface nt_subckt_activity_monitor_if #(
  parameter int WIN_LOG2 = 3,
  parameter int PAT_W    = 4
) ();
  import nt_subckt_activity_monitor_pkg::*;

  // No backpressure: win_done and match_pulse are single-cycle valid strobes
  // with no ready; toggle_cnt/rare_flag are held until the next win_done.
  logic                en;
  logic                din;
  logic [PAT_W-1:0]    pattern;
  logic                win_done;
  logic [WIN_LOG2:0]   toggle_cnt;
  logic                rare_flag;
  logic                match_pulse;
  logic [PAT_W-1:0]    hist;
  state_t              state_dbg;

  modport master (
    output en, din, pattern,
    input  win_done, toggle_cnt, rare_flag, match_pulse, hist, state_dbg
  );

  modport slave (
    input  en, din, pattern,
    output win_done, toggle_cnt, rare_flag, match_pulse, hist, state_dbg
  );

endinterface

// File: rtl/nt_subckt_activity_monitor_toggle_detect.sv
// Holds the previous sample of the observed bit and flags a toggle when the
// current bit differs from it.
module nt_toggle_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic din,
  output logic toggle
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = prev_q;
    if (load) prev_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign toggle = din ^ prev_q;

endmodule

// File: rtl/nt_subckt_activity_monitor.sv
// Windowed toggle counter with rare-activity flag and a pattern watch over
// the most recent PAT_W samples of a single observed bit.
module nt_subckt_activity_monitor
  import nt_subckt_activity_monitor_pkg::*;
#(
  parameter int WIN_LOG2  = WIN_LOG2_DEF,
  parameter int PAT_W     = PAT_W_DEF,
  parameter int TOGGLE_TH = TOGGLE_TH_DEF
) (
  input  logic                          I1470_clk,
  input  logic                          I1477_rst,
  nt_subckt_activity_monitor_if.slave   mon
);

  localparam int                  FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PAT_W);
  localparam logic [WIN_LOG2-1:0] CYC_LAST = '1;
  localparam logic [WIN_LOG2:0]   TOG_TH   = (WIN_LOG2 + 1)'(TOGGLE_TH);

  state_t              state_q, state_d;
  logic [PAT_W-1:0]    hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WIN_LOG2-1:0] cyc_q, cyc_d;
  logic [WIN_LOG2:0]   tog_q, tog_d;
  logic                win_done_q, win_done_d;
  logic [WIN_LOG2:0]   toggle_cnt_q, toggle_cnt_d;
  logic                rare_q, rare_d;
  logic                match_q, match_d;

  logic                load;
  logic                toggle;
  logic [PAT_W-1:0]    hist_shift;
  logic [FILL_W-1:0]   fill_next;
  logic [WIN_LOG2:0]   tog_next;

  nt_toggle_detect u_toggle (
    .clk    (I1470_clk),
    .rst_n  (I1477_rst),
    .load   (load),
    .din    (mon.din),
    .toggle (toggle)
  );

  assign hist_shift = {hist_q[PAT_W-2:0], mon.din};
  assign fill_next  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  assign tog_next   = tog_q + {{WIN_LOG2{1'b0}}, toggle};

  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    fill_d       = fill_q;
    cyc_d        = cyc_q;
    tog_d        = tog_q;
    win_done_d   = 1'b0;
    toggle_cnt_d = toggle_cnt_q;
    rare_d       = rare_q;
    match_d      = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mon.en) state_d = ST_PRIME;
      end

      ST_PRIME: begin
        load    = 1'b1;
        hist_d  = '0;
        fill_d  = '0;
        cyc_d   = '0;
        tog_d   = '0;
        state_d = mon.en ? ST_COUNT : ST_IDLE;
      end

      ST_COUNT: begin
        if (mon.en) begin
          load    = 1'b1;
          hist_d  = hist_shift;
          fill_d  = fill_next;
          tog_d   = tog_next;
          cyc_d   = cyc_q + 1'b1;
          match_d = (fill_next == FILL_MAX) && (hist_shift == mon.pattern);
          // Results are registered on the last sample so they are visible
          // during the REPORT cycle itself.
          if (cyc_q == CYC_LAST) begin
            state_d      = ST_REPORT;
            win_done_d   = 1'b1;
            toggle_cnt_d = tog_next;
            rare_d       = (tog_next < TOG_TH);
          end
        end else begin
          state_d = ST_IDLE;
          tog_d   = '0;
          cyc_d   = '0;
          fill_d  = '0;
        end
      end

      ST_REPORT: begin
        // prev and hist carry over so consecutive windows abut seamlessly.
        cyc_d   = '0;
        tog_d   = '0;
        state_d = mon.en ? ST_COUNT : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state_q      <= ST_IDLE;
      hist_q       <= '0;
      fill_q       <= '0;
      cyc_q        <= '0;
      tog_q        <= '0;
      win_done_q   <= 1'b0;
      toggle_cnt_q <= '0;
      rare_q       <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      cyc_q        <= cyc_d;
      tog_q        <= tog_d;
      win_done_q   <= win_done_d;
      toggle_cnt_q <= toggle_cnt_d;
      rare_q       <= rare_d;
      match_q      <= match_d;
    end
  end

  assign mon.win_done    = win_done_q;
  assign mon.toggle_cnt  = toggle_cnt_q;
  assign mon.rare_flag   = rare_q;
  assign mon.match_pulse = match_q;
  assign mon.hist        = hist_q;
  assign mon.state_dbg   = state_q;

endmodule
